// File: rtl/mem_wb_skid_latch_if.sv
// rtl/mem_wb_skid_latch_if.sv - MEM/WB handshake and status bundle with upstream/downstream modports

interface mem_wb_skid_latch_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    // upstream entry
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_rdata;
    logic [REG_W-1:0]  in_wreg;
    logic              in_final;

    // head entry toward write-back
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_rdata;
    logic [REG_W-1:0]  out_wreg;
    logic              out_final;

    // bookkeeping
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  retired;
    logic              done;

    // driver of entries and consumer of the head (memory stage + write-back side)
    modport master (
        output in_valid, in_ctrl, in_alu, in_rdata, in_wreg, in_final, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu, out_rdata, out_wreg, out_final,
        input  occupancy, retired, done
    );

    // the pipeline register itself
    modport slave (
        input  in_valid, in_ctrl, in_alu, in_rdata, in_wreg, in_final, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu, out_rdata, out_wreg, out_final,
        output occupancy, retired, done
    );
endinterface

// File: rtl/mem_wb_skid_latch.sv
// rtl/mem_wb_skid_latch.sv - MEM/WB pipeline register with valid/ready, optional skid entry, flush and retire count

module mem_wb_skid_latch #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic inicio,
    input  logic activo,
    input  logic flush,
    mem_wb_skid_latch_if.slave bus
);

    localparam int PW = CTRL_W + 2 * DATA_W + REG_W + 1;

    // occupancy doubles as the state: number of entries held
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    skid_q;
    logic [CNT_W-1:0] retired_q;
    logic             done_q;

    logic [PW-1:0]    in_pay;
    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // payload packing; the final tag sits in bit 0
    assign in_pay = {bus.in_ctrl, bus.in_alu, bus.in_rdata, bus.in_wreg, bus.in_final};

    assign out_valid = activo & (state_q != EMPTY);

    // ready: registered-only in skid mode, pass-through of out_ready in flat mode
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = activo & ~inicio & (state_q != FULL);
        end else begin : g_flat_ready
            assign in_ready = activo & ~inicio & (~out_valid | bus.out_ready);
        end
    endgenerate

    assign push = bus.in_valid & in_ready;
    assign pop  = out_valid & bus.out_ready;

    // state, payload and bookkeeping update on the falling edge; activo=0 freezes everything
    always_ff @(negedge clk or posedge inicio) begin
        if (inicio) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            retired_q <= '0;
            done_q    <= 1'b0;
        end else if (activo) begin
            if (flush) begin
                // entries are dropped and a same-edge pop is not retired
                state_q <= EMPTY;
                head_q  <= '0;
                skid_q  <= '0;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (push) begin
                            head_q  <= in_pay;
                            state_q <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_q <= in_pay;
                        end else if (push && (SKID != 0)) begin
                            skid_q  <= in_pay;
                            state_q <= FULL;
                        end else if (pop) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a pop can happen
                        if (pop) begin
                            head_q  <= skid_q;
                            state_q <= ONE;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
                if (pop) begin
                    retired_q <= retired_q + CNT_W'(1);
                    if (head_q[0]) begin
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign {bus.out_ctrl, bus.out_alu, bus.out_rdata, bus.out_wreg, bus.out_final} = head_q;
    assign bus.occupancy = state_q;
    assign bus.retired   = retired_q;
    assign bus.done      = done_q;

endmodule
